// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared types and parameter defaults for the FIFO read-side arbiter.
package fifo_rd_arbiter_pkg;

  localparam int unsigned NumReqDefault    = 4;
  localparam int unsigned DataWidthDefault = 8;
  localparam int unsigned MaxBurstDefault  = 4;

  typedef enum logic {
    StIdle,
    StBurst
  } state_e;

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Round-robin priority picker: first requester above last_gnt, wrapping to index 0.
module rr_pick
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NumReqDefault,
  parameter int unsigned IDX_W   = $clog2(NumReqDefault)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic [NUM_REQ-1:0] pick
);

  logic found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    // Upper segment first, then the wrapped-around lower segment.
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (!found && req[j] && (j > int'(last_gnt))) begin
        pick[j] = 1'b1;
        found   = 1'b1;
      end
    end
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (!found && req[j] && (j <= int'(last_gnt))) begin
        pick[j] = 1'b1;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Burst-limited round-robin arbiter sharing one FIFO read port among NUM_REQ requesters.
module fifo_rd_arbiter
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NumReqDefault,
  parameter int unsigned DATA_WIDTH = DataWidthDefault,
  parameter int unsigned MAX_BURST  = MaxBurstDefault
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  r_en,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [NUM_REQ-1:0] pick;
  logic               req_g;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last_gnt (last_q),
    .pick     (pick)
  );

  assign req_g = |(req & gnt_q);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      // Strobe the owner of this cycle's read when its data arrives.
      rvalid_q <= r_en ? gnt_q : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if ((|req) && !empty) begin
          state_d = StBurst;
          gnt_d   = pick;
          cnt_d   = '0;
          for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (pick[j]) last_d = IDX_W'(j);
          end
        end
      end
      StBurst: begin
        if (r_en) cnt_d = cnt_q + CNT_W'(1);
        if (!req_g || (r_en && (cnt_q == CNT_W'(MAX_BURST - 1)))) begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StBurst);
    r_en = busy && req_g && !empty && (cnt_q < CNT_W'(MAX_BURST));
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign rdata  = fifo_rdata;

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of read requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, is the FIFO read-data width.
REQ-003 Parameter MAX_BURST, default 4, is the maximum number of reads per grant (1..15).
REQ-004 Port rclk, input, 1 bit: the single read-domain clock; all logic is on its rising edge.
REQ-005 Port rrst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port req, input, NUM_REQ bits: one read request per requester, level-sensitive.
REQ-007 Port empty, input, 1 bit: registered FIFO empty flag.
REQ-008 Port fifo_rdata, input, DATA_WIDTH bits: FIFO read data, valid the cycle after r_en.
REQ-009 Port r_en, output, 1 bit: FIFO read enable.
REQ-010 Port gnt, output, NUM_REQ bits: one-hot current grant (all zero when idle).
REQ-011 Port rvalid, output, NUM_REQ bits: one-hot data strobe to the requester owning rdata.
REQ-012 Port rdata, output, DATA_WIDTH bits: read data delivered to requesters.
REQ-013 Port busy, output, 1 bit: high while in BURST.

Function
REQ-014 The FSM SHALL have two states, IDLE and BURST.
REQ-015 In IDLE with any req bit high and empty low, the block SHALL select the first requester with req high, searching round-robin from index (last_gnt+1) mod NUM_REQ, register its one-hot gnt, set last_gnt to it, clear burst_cnt, and enter BURST next cycle.
REQ-016 In IDLE with empty high, no grant SHALL be issued, even if req is non-zero.
REQ-017 In BURST, r_en SHALL equal req[granted] AND NOT empty AND (burst_cnt < MAX_BURST), combinationally; r_en SHALL be 0 in IDLE.
REQ-018 Each cycle r_en is 1, burst_cnt SHALL increment by 1; width is the minimum needed to hold MAX_BURST, with no wrap.
REQ-019 BURST SHALL exit to IDLE at the edge where r_en=1 and burst_cnt=MAX_BURST-1, or at any edge where req[granted]=0; gnt SHALL clear at that edge.
REQ-020 In BURST with empty high and req[granted] high, the block SHALL stall: grant held, r_en=0, no timeout.
REQ-021 rvalid SHALL be the registered gnt AND'd with the registered r_en: high exactly one cycle after each r_en, on the requester that issued it.
REQ-022 rdata SHALL pass fifo_rdata through unregistered; it is meaningful only when any rvalid bit is high.
REQ-023 A burst's trailing rvalid SHALL be delivered even if the FSM has returned to IDLE.
REQ-024 After a burst ends, at least one IDLE cycle SHALL occur before the next grant; minimum grant-to-grant spacing is therefore burst length + 1 cycles.
REQ-025 Simultaneous requests SHALL be served strictly round-robin; no requester waits more than NUM_REQ-1 bursts.
REQ-026 gnt, rvalid, and r_en SHALL each be one-hot or zero at all times.

Reset
REQ-027 While rrst=1 at a rising edge, the block SHALL enter IDLE with gnt=0, rvalid=0, busy=0, burst_cnt=0, and last_gnt=NUM_REQ-1, so requester 0 has first priority.
REQ-028 r_en SHALL be 0 in the cycle after a reset edge, including when reset is asserted mid-burst; a pending rvalid SHALL be discarded.

Structure
REQ-029 A shared package SHALL hold the FSM state enum {IDLE, BURST} and the parameter defaults.
REQ-030 The round-robin priority picker SHALL be a combinational sub-module named rr_pick (inputs req and last_gnt, output one-hot); everything else is in fifo_rd_arbiter.

Verification
REQ-031 Single requester: req=0001, FIFO holds 6 words, MAX_BURST=4 -> 4 r_en pulses, then 1 idle cycle, then 2 more; rvalid[0] for 6 cycles, each one cycle after its r_en.
REQ-032 All requesting: req=1111, FIFO always non-empty, after reset -> grant order 0,1,2,3,0, each burst exactly 4 reads.
REQ-033 Empty stall: grant to requester 2, then empty rises after 2 reads for 5 cycles -> r_en=0 for 5 cycles, gnt stays 0100, then the remaining 2 reads issue.
REQ-034 Early release: requester 1 drops req after 1 read -> FSM reaches IDLE next edge, exactly one rvalid[1], and the next grant goes to requester 2 if it is requesting.
REQ-035 Reset mid-burst: assert rrst in the cycle after the 2nd r_en -> next cycle r_en=0, gnt=0, rvalid=0; after release with req=1000, the first grant goes to requester 3 via round-robin from last_gnt=3.
REQ-036 Empty at start: req=0010, empty=1 -> no grant; when empty falls, gnt=0010 appears the next edge.
